// File: rtl/preg_reclaim_if.sv
// preg_reclaim_if: ROB commit, free-list return and RRAT walk bundle.
// master = ROB/rename side, slave = preg_reclaim_unit.
interface preg_reclaim_if #(
  parameter int ARN_W = 5,
  parameter int PRN_W = 6
);
  logic             commit_valid;
  logic             commit_ready;
  logic             commit_has_dest;
  logic [ARN_W-1:0] commit_areg;
  logic [PRN_W-1:0] commit_preg;

  logic             free_valid;
  logic             free_ready;
  logic [PRN_W-1:0] free_preg;

  logic             recover_req;
  logic             recover_busy;
  logic             rec_valid;
  logic [ARN_W-1:0] rec_areg;
  logic [PRN_W-1:0] rec_preg;
  logic             recover_done;

  modport master (
    output commit_valid,
    output commit_has_dest,
    output commit_areg,
    output commit_preg,
    input  commit_ready,
    input  free_valid,
    input  free_preg,
    output free_ready,
    output recover_req,
    input  recover_busy,
    input  rec_valid,
    input  rec_areg,
    input  rec_preg,
    input  recover_done
  );

  modport slave (
    input  commit_valid,
    input  commit_has_dest,
    input  commit_areg,
    input  commit_preg,
    output commit_ready,
    output free_valid,
    output free_preg,
    input  free_ready,
    input  recover_req,
    output recover_busy,
    output rec_valid,
    output rec_areg,
    output rec_preg,
    output recover_done
  );
endinterface

// File: rtl/preg_reclaim_unit.sv
// preg_reclaim_unit: retirement RAT, superseded-preg return queue and
// flush-time RRAT walk. Optional macro: RECLAIM_BYPASS_EN.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    preg_reclaim_if.slave
//          commit_*  in-order retire handshake from the ROB
//          free_*    freed preg push towards the rename free list
//          recover_req / recover_busy / rec_* / recover_done
//                    RRAT walk, one entry per cycle after a flush
module preg_reclaim_unit #(
  parameter int NUM_A_REGS = 32,
  parameter int NUM_P_REGS = 64,
  parameter int ARN_W      = $clog2(NUM_A_REGS),
  parameter int PRN_W      = $clog2(NUM_P_REGS),
  parameter int FQ_DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  preg_reclaim_if.slave bus
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [ARN_W-1:0] LAST =
    ARN_W'(NUM_A_REGS - 1);
  localparam logic [CNT_W-1:0] FULL =
    CNT_W'(FQ_DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    WALK = 1'b1
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [ARN_W-1:0] widx_q;
  logic [ARN_W-1:0] widx_d;

  logic [PRN_W-1:0] rrat_q [NUM_A_REGS];
  logic [PRN_W-1:0] fq_q   [FQ_DEPTH];

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] head_d;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W-1:0] tail_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             rdy;
  logic             walk_v;
  logic             walk_done;
  logic             acc;
  logic             upd;
  logic             push;
  logic             pop;
  logic             byp;
  logic             q_empty;
  logic [PRN_W-1:0] old_preg;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      widx_q  <= '0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    widx_d    = widx_q;
    rdy       = 1'b0;
    walk_v    = 1'b0;
    walk_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        // rst_n term keeps ready low while reset is held
        rdy = rst_n && (cnt_q < FULL);
        if (bus.recover_req) begin
          state_d = WALK;
          widx_d  = '0;
        end
      end
      WALK: begin
        walk_v = 1'b1;
        if (widx_q == LAST) begin
          walk_done = 1'b1;
          state_d   = IDLE;
          widx_d    = '0;
        end else begin
          widx_d = widx_q + 1'b1;
        end
      end
    endcase
  end

  assign bus.commit_ready = rdy;
  assign bus.recover_busy = walk_v;
  assign bus.rec_valid    = walk_v;
  assign bus.recover_done = walk_done;
  assign bus.rec_areg     = walk_v ? widx_q : '0;
  assign bus.rec_preg     = walk_v ? rrat_q[widx_q] : '0;

  // ---------------- commit / RRAT ----------------
  assign acc      = bus.commit_valid && rdy;
  assign upd      = acc && bus.commit_has_dest;
  assign old_preg = rrat_q[bus.commit_areg];
  assign q_empty  = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_A_REGS; i++) begin
        rrat_q[i] <= PRN_W'(i);
      end
    end else if (upd) begin
      rrat_q[bus.commit_areg] <= bus.commit_preg;
    end
  end

  // ---------------- free-return queue ----------------
`ifdef RECLAIM_BYPASS_EN
  // Empty queue and a willing consumer: hand the old preg
  // straight through instead of spending a cycle in the queue.
  assign byp = upd && q_empty && bus.free_ready;
  assign bus.free_valid = !q_empty || byp;
  assign bus.free_preg  = byp ? old_preg : fq_q[head_q];
`else
  assign byp = 1'b0;
  assign bus.free_valid = !q_empty;
  assign bus.free_preg  = fq_q[head_q];
`endif

  assign push = upd && !byp;
  assign pop  = !q_empty && bus.free_ready;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (push) begin
      tail_d = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FQ_DEPTH; i++) begin
        fq_q[i] <= '0;
      end
    end else if (push) begin
      fq_q[tail_q] <= old_preg;
    end
  end

endmodule
